enigma_rotor_ctrl: RTL and testbench
====================================

// Module: enigma_rotor_ctrl
// PURPOSE
// Rotor-position controller feeding the enigma_1 encoding pipeline. Holds the three rotor positions,
// steps them odometer-style (optionally with Enigma double-step) once per accepted symbol, and
// supplies each pipeline stage with the position that was current when its symbol entered.
// Drives r*_o / r*_d_o of enigma_1 directly; en_val_i is shared with enigma_1.
// PARAMETERS
// R1_INIT_VALUE  1   reset/reload position of rotor 1 (fast rotor), range 1..LETTERS
// R2_INIT_VALUE  1   reset/reload position of rotor 2 (middle rotor), range 1..LETTERS
// R3_INIT_VALUE  1   reset/reload position of rotor 3 (slow rotor), range 1..LETTERS
// R1_NOTCH       22  r1 position whose step-away carries into r2
// R2_NOTCH       5   r2 position whose step-away carries into r3
// DOUBLE_STEP    1   1 = Enigma middle-rotor double-step enabled; 0 = pure odometer
// LETTERS        26  alphabet size; positions are 1..LETTERS
// PORTS
// clk_i         in   1        clock
// rst_i         in   1        asynchronous reset, active-high
// rotors_rst_i  in   1        sync reload of positions to *_INIT_VALUE
// en_val_i      in   1        symbol presented this cycle; rotors step at this edge
// load_i        in   1        sync load of key setting from load_r*_i
// load_r1_i     in   7        rotor 1 key position
// load_r2_i     in   7        rotor 2 key position
// load_r3_i     in   7        rotor 3 key position
// r1_o          out  7        current rotor 1 position (stage 0)
// r1_d_o        out  [5:1][6:0]  r1_o delayed k cycles, k=1..5
// r2_o          out  7        current rotor 2 position
// r2_d_o        out  [4:1][6:0]  r2_o delayed k cycles, k=1..4
// r3_o          out  7        current rotor 3 position
// r3_d_o        out  [3:1][6:0]  r3_o delayed k cycles, k=1..3
// step_cnt_o    out  16       accepted-symbol counter, wraps 65535->0
// BEHAVIOUR
// - Async reset: r1/r2/r3_o = R*_INIT_VALUE; every delay tap = its rotor's INIT_VALUE; step_cnt_o = 0.
// - r*_o are registers, no comb path from inputs. Symbol with en_val_i=1 in cycle t uses r*_o of cycle t.
// - Priority at each edge: rotors_rst_i > load_i > step (en_val_i). Lower-priority action is dropped.
// - rotors_rst_i: positions <= INIT; step_cnt_o <= 0; delay lines NOT flushed (still shift).
// - load_i: each rotor takes load_r*_i if 1..LETTERS, else keeps its value (per rotor); no step.
// - Step (en_val_i=1, no reset/load), using pre-edge values:
//   r1 <= r1+1, LETTERS wraps to 1.
//   c1 = (r1==R1_NOTCH); ds = DOUBLE_STEP && (r2==R2_NOTCH).
//   r2 steps (+1, wrap) if c1 || ds. r3 steps (+1, wrap) if ds, or if c1 && r2==R2_NOTCH.
//   step_cnt_o <= step_cnt_o+1.
// - en_val_i=0: positions hold.
// - Delay lines shift EVERY cycle regardless of en_val_i: d[1]<=r*_o, d[k]<=d[k-1]. Alignment with the
//   enigma_1 stages depends on this.
// - Positions are always in 1..LETTERS; 0 is never driven after reset.
// - Async reset mid-stream resets all state at once; in-flight symbols are lost (enigma_1 resets too).
// TESTING
// - Reset, defaults: r1/r2/r3_o=1,1,1; all taps=1; step_cnt_o=0.
// - 3 consecutive en_val_i from 1,1,1: r1_o=2,3,4 on successive cycles; r1_d_o[1] lags by 1 cycle, [5] by 5.
// - Notch carry: load 22,1,1, one step -> 23,2,1. Load 26,1,1, step -> 1,1,1 (wrap, no carry).
// - Double-step, DOUBLE_STEP=1: load 21,4,1, three steps -> 22,4,1 -> 23,5,1 -> 24,6,2.
//   Same with DOUBLE_STEP=0 -> 24,5,1.
// - Priority: load_i+en_val_i same edge -> load values, no step. rotors_rst_i+load_i -> INIT.
//   load_r2_i=0 or 27 -> r2 unchanged, r1/r3 loaded.
// - Idle gaps: en_val_i=0 for 4 cycles -> positions hold; taps converge to the held value after 5 cycles.

Source files
------------

// File: rtl/enigma_rotor_ctrl.sv
// Rotor-position controller for the enigma_1 pipeline: odometer/double-step rotor stepping,
// key loading, accepted-symbol counter and per-stage delayed position taps.
module enigma_rotor_ctrl #(
    parameter int R1_INIT_VALUE = 1,
    parameter int R2_INIT_VALUE = 1,
    parameter int R3_INIT_VALUE = 1,
    parameter int R1_NOTCH      = 22,
    parameter int R2_NOTCH      = 5,
    parameter int DOUBLE_STEP   = 1,
    parameter int LETTERS       = 26
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            rotors_rst_i,
    input  logic            en_val_i,
    input  logic            load_i,
    input  logic [6:0]      load_r1_i,
    input  logic [6:0]      load_r2_i,
    input  logic [6:0]      load_r3_i,
    output logic [6:0]      r1_o,
    output logic [5:1][6:0] r1_d_o,
    output logic [6:0]      r2_o,
    output logic [4:1][6:0] r2_d_o,
    output logic [6:0]      r3_o,
    output logic [3:1][6:0] r3_d_o,
    output logic [15:0]     step_cnt_o
);

    localparam logic [6:0] R1_INIT   = R1_INIT_VALUE[6:0];
    localparam logic [6:0] R2_INIT   = R2_INIT_VALUE[6:0];
    localparam logic [6:0] R3_INIT   = R3_INIT_VALUE[6:0];
    localparam logic [6:0] R1_NOTCH_W = R1_NOTCH[6:0];
    localparam logic [6:0] R2_NOTCH_W = R2_NOTCH[6:0];
    localparam logic [6:0] LETTERS_W = LETTERS[6:0];
    localparam logic       DS_EN     = (DOUBLE_STEP != 0);

    function automatic logic [6:0] wrap_inc(input logic [6:0] p);
        return (p == LETTERS_W) ? 7'd1 : p + 7'd1;
    endfunction

    function automatic logic load_ok(input logic [6:0] v);
        return (v != 7'd0) && (v <= LETTERS_W);
    endfunction

    logic [6:0]  r1_q, r1_d;
    logic [6:0]  r2_q, r2_d;
    logic [6:0]  r3_q, r3_d;
    logic [15:0] cnt_q, cnt_d;

    logic c1;
    logic r2_at_notch;
    logic ds;

    assign c1          = (r1_q == R1_NOTCH_W);
    assign r2_at_notch = (r2_q == R2_NOTCH_W);
    assign ds          = DS_EN && r2_at_notch;

    always_comb begin
        r1_d  = r1_q;
        r2_d  = r2_q;
        r3_d  = r3_q;
        cnt_d = cnt_q;
        if (rotors_rst_i) begin
            r1_d  = R1_INIT;
            r2_d  = R2_INIT;
            r3_d  = R3_INIT;
            cnt_d = 16'd0;
        end else if (load_i) begin
            // Out-of-range key digits leave only that rotor untouched
            if (load_ok(load_r1_i)) r1_d = load_r1_i;
            if (load_ok(load_r2_i)) r2_d = load_r2_i;
            if (load_ok(load_r3_i)) r3_d = load_r3_i;
        end else if (en_val_i) begin
            r1_d  = wrap_inc(r1_q);
            if (c1 || ds)                 r2_d = wrap_inc(r2_q);
            if (ds || (c1 && r2_at_notch)) r3_d = wrap_inc(r3_q);
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r1_q  <= R1_INIT;
            r2_q  <= R2_INIT;
            r3_q  <= R3_INIT;
            cnt_q <= 16'd0;
        end else begin
            r1_q  <= r1_d;
            r2_q  <= r2_d;
            r3_q  <= r3_d;
            cnt_q <= cnt_d;
        end
    end

    // Taps shift every cycle so tap k always matches pipeline stage k, idle or not
    logic [6:0] r1_dly_q [1:5];
    logic [6:0] r2_dly_q [1:4];
    logic [6:0] r3_dly_q [1:3];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 1; k <= 5; k++) r1_dly_q[k] <= R1_INIT;
        end else begin
            r1_dly_q[1] <= r1_q;
            for (int k = 2; k <= 5; k++) r1_dly_q[k] <= r1_dly_q[k-1];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 1; k <= 4; k++) r2_dly_q[k] <= R2_INIT;
        end else begin
            r2_dly_q[1] <= r2_q;
            for (int k = 2; k <= 4; k++) r2_dly_q[k] <= r2_dly_q[k-1];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 1; k <= 3; k++) r3_dly_q[k] <= R3_INIT;
        end else begin
            r3_dly_q[1] <= r3_q;
            for (int k = 2; k <= 3; k++) r3_dly_q[k] <= r3_dly_q[k-1];
        end
    end

    for (genvar gi = 1; gi <= 5; gi++) begin : g_r1_tap
        assign r1_d_o[gi] = r1_dly_q[gi];
    end
    for (genvar gi = 1; gi <= 4; gi++) begin : g_r2_tap
        assign r2_d_o[gi] = r2_dly_q[gi];
    end
    for (genvar gi = 1; gi <= 3; gi++) begin : g_r3_tap
        assign r3_d_o[gi] = r3_dly_q[gi];
    end

    assign r1_o       = r1_q;
    assign r2_o       = r2_q;
    assign r3_o       = r3_q;
    assign step_cnt_o = cnt_q;

endmodule

// File: tb/tb_enigma_rotor_ctrl.sv
// Directed bench for enigma_rotor_ctrl: vector table plus hand sequences for taps and async reset.
module tb_enigma_rotor_ctrl;

    logic            clk = 1'b0;
    logic            rst_i;
    logic            rotors_rst_i;
    logic            en_val_i;
    logic            load_i;
    logic [6:0]      load_r1_i, load_r2_i, load_r3_i;

    logic [6:0]      r1_o, r2_o, r3_o;
    logic [5:1][6:0] r1_d_o;
    logic [4:1][6:0] r2_d_o;
    logic [3:1][6:0] r3_d_o;
    logic [15:0]     step_cnt_o;

    logic [6:0]      od_r1_o, od_r2_o, od_r3_o;
    logic [5:1][6:0] od_r1_d_o;
    logic [4:1][6:0] od_r2_d_o;
    logic [3:1][6:0] od_r3_d_o;
    logic [15:0]     od_step_cnt_o;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    enigma_rotor_ctrl u_ds (
        .clk_i(clk), .rst_i(rst_i), .rotors_rst_i(rotors_rst_i), .en_val_i(en_val_i),
        .load_i(load_i), .load_r1_i(load_r1_i), .load_r2_i(load_r2_i), .load_r3_i(load_r3_i),
        .r1_o(r1_o), .r1_d_o(r1_d_o), .r2_o(r2_o), .r2_d_o(r2_d_o),
        .r3_o(r3_o), .r3_d_o(r3_d_o), .step_cnt_o(step_cnt_o)
    );

    enigma_rotor_ctrl #(.DOUBLE_STEP(0)) u_od (
        .clk_i(clk), .rst_i(rst_i), .rotors_rst_i(rotors_rst_i), .en_val_i(en_val_i),
        .load_i(load_i), .load_r1_i(load_r1_i), .load_r2_i(load_r2_i), .load_r3_i(load_r3_i),
        .r1_o(od_r1_o), .r1_d_o(od_r1_d_o), .r2_o(od_r2_o), .r2_d_o(od_r2_d_o),
        .r3_o(od_r3_o), .r3_d_o(od_r3_d_o), .step_cnt_o(od_step_cnt_o)
    );

    typedef struct {
        logic rr; logic ld; logic en;
        int l1; int l2; int l3;
        int e1; int e2; int e3; int o2; int o3; int cnt;
    } vec_t;

    vec_t vecs [20];
    int   eh   [14];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rr, input logic ld, input logic en,
                         input int l1, input int l2, input int l3);
        rotors_rst_i = rr;
        load_i       = ld;
        en_val_i     = en;
        load_r1_i    = 7'(l1);
        load_r2_i    = 7'(l2);
        load_r3_i    = 7'(l3);
    endtask

    initial begin
        //          rr    ld    en    l1  l2  l3  e1  e2 e3 o2 o3 cnt
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 0,  0,  0,  2,  1, 1, 1, 1, 1};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 0,  0,  0,  3,  1, 1, 1, 1, 2};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 0,  0,  0,  4,  1, 1, 1, 1, 3};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 22, 1,  1,  22, 1, 1, 1, 1, 3};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 0,  0,  0,  23, 2, 1, 2, 1, 4};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 26, 1,  1,  26, 1, 1, 1, 1, 4};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 0,  0,  0,  1,  1, 1, 1, 1, 5};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 21, 4,  1,  21, 4, 1, 4, 1, 5};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 0,  0,  0,  22, 4, 1, 4, 1, 6};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 0,  0,  0,  23, 5, 1, 5, 1, 7};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 0,  0,  0,  24, 6, 2, 5, 1, 8};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 5,  7,  9,  5,  7, 9, 7, 9, 8};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 10, 10, 10, 1,  1, 1, 1, 1, 0};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 3,  0,  4,  3,  1, 4, 1, 4, 0};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 6,  27, 8,  6,  1, 8, 1, 8, 0};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 0,  0,  0,  7,  1, 8, 1, 8, 1};
        for (int i = 16; i < 20; i++)
            vecs[i] = '{1'b0, 1'b0, 1'b0, 0, 0, 0, 7, 1, 8, 1, 8, 1};

        // Expected r1 per cycle of the tap-lag sequence; first five entries are the converged prehistory
        for (int i = 0; i < 5; i++) eh[i] = 7;
        eh[5] = 1; eh[6] = 2; eh[7] = 3; eh[8] = 4;
        for (int i = 9; i < 14; i++) eh[i] = 4;

        rst_i = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 0, 0, 0);
        #12;
        rst_i = 1'b0;
        #2;

        chk("reset r1", int'(r1_o), 1);
        chk("reset r2", int'(r2_o), 1);
        chk("reset r3", int'(r3_o), 1);
        chk("reset cnt", int'(step_cnt_o), 0);
        for (int k = 1; k <= 5; k++) chk($sformatf("reset r1_d[%0d]", k), int'(r1_d_o[k]), 1);
        for (int k = 1; k <= 4; k++) chk($sformatf("reset r2_d[%0d]", k), int'(r2_d_o[k]), 1);
        for (int k = 1; k <= 3; k++) chk($sformatf("reset r3_d[%0d]", k), int'(r3_d_o[k]), 1);
        $display("reset: r=%0d,%0d,%0d cnt=%0d", r1_o, r2_o, r3_o, step_cnt_o);

        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].rr, vecs[i].ld, vecs[i].en, vecs[i].l1, vecs[i].l2, vecs[i].l3);
            tick();
            chk($sformatf("vec%0d r1", i), int'(r1_o), vecs[i].e1);
            chk($sformatf("vec%0d r2", i), int'(r2_o), vecs[i].e2);
            chk($sformatf("vec%0d r3", i), int'(r3_o), vecs[i].e3);
            chk($sformatf("vec%0d cnt", i), int'(step_cnt_o), vecs[i].cnt);
            chk($sformatf("vec%0d od r1", i), int'(od_r1_o), vecs[i].e1);
            chk($sformatf("vec%0d od r2", i), int'(od_r2_o), vecs[i].o2);
            chk($sformatf("vec%0d od r3", i), int'(od_r3_o), vecs[i].o3);
            $display("vec%0d rr=%0b ld=%0b en=%0b -> r=%0d,%0d,%0d od=%0d,%0d,%0d cnt=%0d", i,
                     vecs[i].rr, vecs[i].ld, vecs[i].en, r1_o, r2_o, r3_o,
                     od_r1_o, od_r2_o, od_r3_o, step_cnt_o);
        end

        // Fifth idle cycle: every tap now holds the parked position
        drive(1'b0, 1'b0, 1'b0, 0, 0, 0);
        tick();
        for (int k = 1; k <= 5; k++) chk($sformatf("idle r1_d[%0d]", k), int'(r1_d_o[k]), 7);
        for (int k = 1; k <= 4; k++) chk($sformatf("idle r2_d[%0d]", k), int'(r2_d_o[k]), 1);
        for (int k = 1; k <= 3; k++) chk($sformatf("idle r3_d[%0d]", k), int'(r3_d_o[k]), 8);
        $display("idle taps: r1_d5=%0d r2_d4=%0d r3_d3=%0d", r1_d_o[5], r2_d_o[4], r3_d_o[3]);

        // Tap lag: load 1,1,1 then three steps, then idle
        for (int n = 0; n < 9; n++) begin
            if (n == 0)      drive(1'b0, 1'b1, 1'b0, 1, 1, 1);
            else if (n <= 3) drive(1'b0, 1'b0, 1'b1, 0, 0, 0);
            else             drive(1'b0, 1'b0, 1'b0, 0, 0, 0);
            tick();
            chk($sformatf("lag%0d r1", n), int'(r1_o), eh[n+5]);
            for (int k = 1; k <= 5; k++)
                chk($sformatf("lag%0d r1_d[%0d]", n, k), int'(r1_d_o[k]), eh[n+5-k]);
            $display("lag%0d r1=%0d d=%0d,%0d,%0d,%0d,%0d", n, r1_o,
                     r1_d_o[1], r1_d_o[2], r1_d_o[3], r1_d_o[4], r1_d_o[5]);
        end

        // Asynchronous reset mid-cycle takes effect without a clock edge
        #2;
        rst_i = 1'b1;
        #1;
        chk("async r1", int'(r1_o), 1);
        chk("async r1_d[1]", int'(r1_d_o[1]), 1);
        chk("async cnt", int'(step_cnt_o), 0);
        $display("async reset: r1=%0d d1=%0d cnt=%0d", r1_o, r1_d_o[1], step_cnt_o);
        #3;
        rst_i = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 0, 0, 0);
        tick();
        chk("post-reset step r1", int'(r1_o), 2);
        chk("post-reset step cnt", int'(step_cnt_o), 1);
        $display("post-reset step: r1=%0d cnt=%0d", r1_o, step_cnt_o);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
